// File: rtl/led_counter.sv
// Free-running counter whose top four bits drive the board LEDs.
// Counting waits for a lock flag that models PLL lock after reset release.
module led_counter #(
  parameter int WIDTH       = 28,
  parameter int LOCK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [3:0] LED
);

  localparam int TW = (LOCK_CYCLES < 1) ? 1 : $clog2(LOCK_CYCLES + 1);
  localparam logic [TW-1:0] LOCK_MAX  = TW'(LOCK_CYCLES);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_CYCLES - 1);

  logic [WIDTH-1:0] count;
  logic [TW-1:0]    lock_timer;
  logic             locked;

  // locked rises on the same edge that lock_timer reaches LOCK_CYCLES
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_timer <= '0;
      locked     <= 1'b0;
    end else begin
      if (lock_timer != LOCK_MAX)
        lock_timer <= lock_timer + TW'(1);
      locked <= locked || (lock_timer >= LOCK_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (enable && locked)
      count <= count + WIDTH'(1);
  end

  assign LED = count[WIDTH-1:WIDTH-4];

endmodule

// File: tb/tb_led_counter.sv
// Directed bench for led_counter: an 8-bit instance walks lock, gating, wrap
// and mid-count reset; a default-size instance runs the board-level timeline.
module tb_led_counter;

  logic       clk = 1'b0;
  logic       reset8, enable8;
  logic [3:0] led8;
  logic       reset28, enable28;
  logic [3:0] led28;
  logic       done28 = 1'b0;

  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  led_counter #(.WIDTH(8), .LOCK_CYCLES(500)) d8 (
    .clk(clk), .reset(reset8), .enable(enable8), .LED(led8)
  );

  led_counter d28 (
    .clk(clk), .reset(reset28), .enable(enable28), .LED(led28)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input int n);
    reset8  = r;
    enable8 = e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Board-level timeline on the default-size instance
  initial begin
    reset28  = 1'b0;
    enable28 = 1'b0;
    #1500   reset28  = 1'b1;
    #1350   reset28  = 1'b0;
    #2500   enable28 = 1'b1;
    #10000  enable28 = 1'b0;
    #50;
    checkOutput("top_count", 32'(d28.count), 32'd750);
    checkOutput("top_led",   32'(led28), 32'h0);
    checkOutput("top_lock",  32'(d28.locked), 32'd1);
    done28 = 1'b1;
  end

  initial begin
    int expCount;

    applyStimulus(1'b1, 1'b0, 3);
    checkOutput("rst_led",    32'(led8), 32'h0);
    checkOutput("rst_count",  32'(d8.count), 32'd0);
    checkOutput("rst_locked", 32'(d8.locked), 32'd0);

    applyStimulus(1'b0, 1'b0, 250);
    applyStimulus(1'b0, 1'b1, 249);
    checkOutput("prelock_count",  32'(d8.count), 32'd0);
    checkOutput("prelock_locked", 32'(d8.locked), 32'd0);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("lock_edge_locked", 32'(d8.locked), 32'd1);
    checkOutput("lock_edge_count",  32'(d8.count), 32'd0);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("first_inc", 32'(d8.count), 32'd1);
    applyStimulus(1'b0, 1'b1, 15);
    checkOutput("cnt16",     32'(d8.count), 32'd16);
    checkOutput("cnt16_led", 32'(led8), 32'h1);

    applyStimulus(1'b0, 1'b1, 84);
    checkOutput("cnt100", 32'(d8.count), 32'd100);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("freeze_now", 32'(d8.count), 32'd100);
    applyStimulus(1'b0, 1'b0, 49);
    checkOutput("freeze_hold", 32'(d8.count), 32'd100);
    applyStimulus(1'b0, 1'b1, 20);
    checkOutput("resume120",     32'(d8.count), 32'd120);
    checkOutput("resume120_led", 32'(led8), 32'h7);

    applyStimulus(1'b0, 1'b1, 135);
    checkOutput("max_count", 32'(d8.count), 32'd255);
    checkOutput("max_led",   32'(led8), 32'hf);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("wrap_count", 32'(d8.count), 32'd0);
    checkOutput("wrap_led",   32'(led8), 32'h0);

    // Full lap: each LED value should persist for 16 consecutive counts
    expCount = 0;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b0, 1'b1, 1);
      expCount = (expCount + 1) % 256;
      checkOutput("lap_led", 32'(led8), 32'(expCount / 16));
    end
    checkOutput("lap_count", 32'(d8.count), 32'd0);

    applyStimulus(1'b0, 1'b1, 37);
    checkOutput("cnt37", 32'(d8.count), 32'd37);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("midrst_count",  32'(d8.count), 32'd0);
    checkOutput("midrst_locked", 32'(d8.locked), 32'd0);
    checkOutput("midrst_led",    32'(led8), 32'h0);
    applyStimulus(1'b0, 1'b1, 499);
    checkOutput("relock_wait_count",  32'(d8.count), 32'd0);
    checkOutput("relock_wait_locked", 32'(d8.locked), 32'd0);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("relock_locked", 32'(d8.locked), 32'd1);
    checkOutput("relock_count",  32'(d8.count), 32'd0);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("relock_inc", 32'(d8.count), 32'd1);

    for (int i = 0; i < 5000 && !done28; i++) @(posedge clk);
    checkOutput("top_done", 32'(done28), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
